// File: rtl/mem_bus_responder_pkg.sv
// Shared memory-map constants, region decode and STATUS layout for mem_bus_responder.
// Offsets and STATUS bit positions here are the contract with CPU tests and firmware.
package mem_bus_responder_pkg;

  localparam logic [3:0] OFF_TX_DATA = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h4;
  localparam logic [3:0] OFF_TIMER   = 4'h8;

  typedef enum logic [1:0] {
    RGN_RAM,
    RGN_MMIO,
    RGN_NONE
  } region_e;

  typedef struct packed {
    logic [7:0] count;
    logic       ovf;
    logic       full;
    logic       empty;
  } status_t;

  // RAM takes priority in case the MMIO window is ever placed inside RAM space.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input logic [31:0] ram_bytes,
                                            input logic [31:0] mmio_base);
    if (addr < ram_bytes) return RGN_RAM;
    if (addr[31:4] == mmio_base[31:4]) return RGN_MMIO;
    return RGN_NONE;
  endfunction

  function automatic logic [31:0] pack_status(input status_t s);
    return {16'b0, s.count, 5'b0, s.ovf, s.full, s.empty};
  endfunction

endpackage

// File: rtl/mem_resp_tx_fifo.sv
// Synchronous byte FIFO: head visible combinationally, push lands one cycle later.
// A push into a full FIFO is accepted only when a pop happens in the same cycle, else dropped.
module mem_resp_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 8,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] push_dat_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_dat_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          push_drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    empty_o     = (count_q == '0);
    full_o      = (count_q == CW'(DEPTH));
    do_pop      = pop_i && !empty_o;
    do_push     = push_i && (!full_o || do_pop);
    push_drop_o = push_i && !do_push;
    wr_ptr_d    = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d     = count_q;
    if (do_push && !do_pop) count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
    count_o     = count_q;
    head_dat_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/mem_bus_responder.sv
// CPU memory target: word RAM + 16-byte MMIO window (TX FIFO, STATUS, TIMER under MEM_BUS_RESPONDER_TIMER_EN).
// Reads combinational, writes at posedge; tx_valid/tx_ready backpressure, full FIFO drops pushes and sets ovf.
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int          RAM_WORDS     = 4096,
  parameter int          TX_FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE     = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wenable,
  output logic [31:0] mem_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_err
);

  localparam int          RAM_AW    = $clog2(RAM_WORDS);
  localparam int          CNT_W     = $clog2(TX_FIFO_DEPTH) + 1;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  region_e        rgn;
  logic [1:0]     byte_off, reg_sel;
  logic [7:0]     lanes_wide;
  logic [3:0]     lanes;
  logic           lanes_dropped;
  logic [31:0]    wdata_sh;
  logic           wr_any, mmio_wr;
  logic [31:0]    ram_q [RAM_WORDS];
  logic [31:0]    rd_word, status_word, timer_word;
  logic           bus_err_q, bus_err_d;
  logic           ovf_q, ovf_d, ovf_clr;
  logic           push, pop, push_drop, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  status_t        status;

  // Byte-lane steering: the CPU presents sub-word data/enables right-aligned.
  always_comb begin
    rgn           = decode_region(mem_addr, RAM_BYTES, MMIO_BASE);
    byte_off      = mem_addr[1:0];
    reg_sel       = mem_addr[3:2];
    lanes_wide    = {4'b0000, mem_wenable} << byte_off;
    lanes         = lanes_wide[3:0];
    lanes_dropped = |lanes_wide[7:4];
    wdata_sh      = mem_wdata << {byte_off, 3'b000};
    wr_any        = rst_n && (mem_wenable != 4'b0000);
    mmio_wr       = wr_any && (rgn == RGN_MMIO);
    push          = mmio_wr && (reg_sel == OFF_TX_DATA[3:2]) && lanes[0];
    ovf_clr       = mmio_wr && (reg_sel == OFF_STATUS[3:2]) && lanes[0] && wdata_sh[2];
    pop           = tx_valid && tx_ready;
    bus_err_d     = wr_any && (lanes_dropped || (rgn == RGN_NONE));
    ovf_d         = ovf_q;
    if (push_drop) ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  mem_resp_tx_fifo #(
    .DEPTH (TX_FIFO_DEPTH),
    .DW    (8)
  ) u_tx_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_dat_i  (wdata_sh[7:0]),
    .pop_i       (pop),
    .head_dat_o  (tx_data),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .push_drop_o (push_drop)
  );

  assign tx_valid = !fifo_empty;
  assign bus_err  = bus_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_err_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      bus_err_q <= bus_err_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_any && (rgn == RGN_RAM)) begin
      for (int i = 0; i < 4; i++) begin
        if (lanes[i]) ram_q[mem_addr[RAM_AW+1:2]][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

`ifdef MEM_BUS_RESPONDER_TIMER_EN
  logic [31:0] timer_q, timer_d;

  // A bus write replaces the increment for that cycle; unwritten bytes hold.
  always_comb begin
    timer_d = timer_q + 32'd1;
    if (mmio_wr && (reg_sel == OFF_TIMER[3:2])) begin
      timer_d = timer_q;
      for (int i = 0; i < 4; i++) begin
        if (lanes[i]) timer_d[8*i +: 8] = wdata_sh[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) timer_q <= '0;
    else        timer_q <= timer_d;
  end

  assign timer_word = timer_q;
`else
  assign timer_word = '0;
`endif

  always_comb begin
    status.count = 8'(fifo_count);
    status.ovf   = ovf_q;
    status.full  = fifo_full;
    status.empty = fifo_empty;
    status_word  = pack_status(status);
    rd_word      = '0;
    case (rgn)
      RGN_RAM:  rd_word = ram_q[mem_addr[RAM_AW+1:2]];
      RGN_MMIO: begin
        if (reg_sel == OFF_STATUS[3:2])     rd_word = status_word;
        else if (reg_sel == OFF_TIMER[3:2]) rd_word = timer_word;
      end
      default:  rd_word = '0;
    endcase
    mem_rdata = rst_n ? (rd_word >> {byte_off, 3'b000}) : '0;
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: vector table, hand sequences, randomized model run.
// Inputs change 1ns after posedge; outputs are sampled 1-2ns after posedge.
module tb_mem_bus_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wenable;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, bus_err;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] MMIO   = 32'h8000_0000;
  localparam logic [31:0] RBASE  = 32'h0000_1000;
  localparam int          FDEPTH = 8;

  always #5 clk = ~clk;

  mem_bus_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wenable (mem_wenable),
    .mem_rdata   (mem_rdata),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .bus_err     (bus_err)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wen;
    logic [31:0] exp;   // expected bus_err for writes, mem_rdata for reads
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit wr, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] m, input logic [31:0] e, input string n);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = d; v.wen = m; v.exp = e; v.name = n;
    return v;
  endfunction

  function automatic logic [31:0] exp_status(input int cnt, input bit ovf);
    return 32'((cnt << 8) + (ovf ? 4 : 0) + ((cnt == FDEPTH) ? 2 : 0) + ((cnt == 0) ? 1 : 0));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    mem_addr = a; mem_wdata = d; mem_wenable = m;
    @(posedge clk); #1;
    mem_wenable = 4'b0000;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    mem_addr = a; mem_wenable = 4'b0000;
    #1;
    d = mem_rdata;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  q[$];
    logic [7:0]  ram_m [256];
    bit          ovf_m;

    rst_n = 1'b0; mem_addr = 32'h100; mem_wdata = '0; mem_wenable = '0; tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset rdata", mem_rdata, 32'h0);
    check("reset tx_valid", 32'(tx_valid), 32'h0);
    check("reset tx_data", 32'(tx_data), 32'h0);
    check("reset bus_err", 32'(bus_err), 32'h0);
    rst_n = 1'b1;
    bus_read(MMIO + 4, rd);
    check("reset status", rd, exp_status(0, 0));
    idle();

    vecs.push_back(mk(1, 32'h100, 32'hDEADBEEF, 4'hF, 0, "sw 100"));
    vecs.push_back(mk(0, 32'h100, 0, 0, 32'hDEADBEEF, "lw 100"));
    vecs.push_back(mk(0, 32'h102, 0, 0, 32'h0000DEAD, "rd 102"));
    vecs.push_back(mk(0, 32'h101, 0, 0, 32'h00DEADBE, "rd 101"));
    vecs.push_back(mk(0, 32'h103, 0, 0, 32'h000000DE, "rd 103"));
    vecs.push_back(mk(1, 32'h200, 32'h11223344, 4'hF, 0, "sw 200"));
    vecs.push_back(mk(1, 32'h201, 32'h000000AA, 4'h1, 0, "sb 201"));
    vecs.push_back(mk(0, 32'h200, 0, 0, 32'h1122AA44, "rd after sb"));
    vecs.push_back(mk(1, 32'h203, 32'h0000BEEF, 4'h3, 1, "sh 203 misaligned"));
    vecs.push_back(mk(0, 32'h200, 0, 0, 32'hEF22AA44, "rd after sh 203"));
    vecs.push_back(mk(1, 32'h202, 32'h00005566, 4'h3, 0, "sh 202"));
    vecs.push_back(mk(0, 32'h200, 0, 0, 32'h5566AA44, "rd after sh 202"));
    vecs.push_back(mk(1, 32'h3FFC, 32'hCAFEF00D, 4'hF, 0, "sw last word"));
    vecs.push_back(mk(0, 32'h3FFC, 0, 0, 32'hCAFEF00D, "rd last word"));
    vecs.push_back(mk(1, 32'h4000, 32'h12345678, 4'hF, 1, "sw past ram"));
    vecs.push_back(mk(0, 32'h4000, 0, 0, 32'h0, "rd past ram"));
    vecs.push_back(mk(0, 32'h0000, 0, 0, 32'h0, "rd ram0 vs past ram"));
    vecs.push_back(mk(1, MMIO + 12, 32'h12345678, 4'hF, 0, "sw reserved"));
    vecs.push_back(mk(0, MMIO + 12, 0, 0, 32'h0, "rd reserved"));
    vecs.push_back(mk(0, MMIO, 0, 0, 32'h0, "rd tx_data reg"));
    vecs.push_back(mk(1, MMIO + 16, 32'h1, 4'hF, 1, "sw past window"));
    vecs.push_back(mk(0, MMIO + 4, 0, 0, 32'h00000001, "status idle"));

    // RAM word 0 has no defined contents yet, so initialise it before the table reads it.
    bus_write(32'h0, 32'h0, 4'hF);
    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        bus_write(vecs[i].addr, vecs[i].wdata, vecs[i].wen);
        check({"err ", vecs[i].name}, 32'(bus_err), vecs[i].exp);
        if (vecs[i].exp != 0) begin
          idle();
          check({"err pulse end ", vecs[i].name}, 32'(bus_err), 32'h0);
        end
      end else begin
        bus_read(vecs[i].addr, rd);
        check(vecs[i].name, rd, vecs[i].exp);
        idle();
      end
    end

    // Overflow with consumer stalled, then in-order drain.
    tx_ready = 1'b0;
    mem_addr = MMIO; mem_wdata = 32'hA0; mem_wenable = 4'h1;
    #1;
    check("tx_valid before first push", 32'(tx_valid), 32'h0);
    @(posedge clk); #1;
    mem_wenable = 4'h0;
    check("tx_valid one cycle after push", 32'(tx_valid), 32'h1);
    for (int i = 1; i < 9; i++) bus_write(MMIO, 32'(8'hA0 + i), 4'h1);
    bus_read(MMIO + 4, rd);
    check("status full+ovf", rd, exp_status(8, 1));
    check("head while stalled", 32'(tx_data), 32'hA0);
    idle();
    check("head stable while stalled", 32'(tx_data), 32'hA0);
    tx_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("drain valid", 32'(tx_valid), 32'h1);
      check("drain byte", 32'(tx_data), 32'(8'hA0 + k));
      idle();
    end
    tx_ready = 1'b0;
    check("drained valid", 32'(tx_valid), 32'h0);
    bus_read(MMIO + 4, rd);
    check("status empty ovf", rd, exp_status(0, 1));
    idle();
    bus_write(MMIO + 4, 32'h4, 4'hF);
    bus_read(MMIO + 4, rd);
    check("status ovf cleared", rd, exp_status(0, 0));
    idle();

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 8; i++) bus_write(MMIO, 32'(8'hB0 + i), 4'h1);
    bus_read(MMIO + 4, rd);
    check("status full", rd, exp_status(8, 0));
    mem_addr = MMIO; mem_wdata = 32'hB8; mem_wenable = 4'h1; tx_ready = 1'b1;
    @(posedge clk); #1;
    mem_wenable = 4'h0; tx_ready = 1'b0;
    bus_read(MMIO + 4, rd);
    check("status full push+pop", rd, exp_status(8, 0));
    check("head after push+pop", 32'(tx_data), 32'hB1);
    tx_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("drain2 byte", 32'(tx_data), 32'(8'hB1 + k));
      idle();
    end
    tx_ready = 1'b0;
    check("drain2 empty", 32'(tx_valid), 32'h0);

`ifdef MEM_BUS_RESPONDER_TIMER_EN
    bus_write(MMIO + 8, 32'hFFFF_FFFE, 4'hF);
    check("timer write err", 32'(bus_err), 32'h0);
    bus_read(MMIO + 8, rd);
    check("timer loaded", rd, 32'hFFFF_FFFE);
    idle();
    bus_read(MMIO + 8, rd);
    check("timer +1", rd, 32'hFFFF_FFFF);
    idle();
    bus_read(MMIO + 8, rd);
    check("timer wrap", rd, 32'h0);
`else
    bus_write(MMIO + 8, 32'h1234_5678, 4'hF);
    check("timer-off write err", 32'(bus_err), 32'h0);
    bus_read(MMIO + 8, rd);
    check("timer-off read", rd, 32'h0);
`endif
    idle();

    // Randomized run against a byte-level RAM model and a queue-based FIFO model.
    for (int w = 0; w < 64; w++) begin
      logic [31:0] v;
      v = $urandom;
      bus_write(RBASE + 32'(4 * w), v, 4'hF);
      for (int b = 0; b < 4; b++) ram_m[4 * w + b] = v[8*b +: 8];
    end
    q.delete();
    ovf_m = 1'b0;
    for (int it = 0; it < 600; it++) begin
      int          op, sz, off;
      bit          is_rd, is_st, is_push, is_wr, is_clr, exp_err;
      logic [31:0] a, d, exp_rd;
      logic [3:0]  m;
      op = $urandom_range(0, 9);
      d = $urandom;
      is_rd = 0; is_st = 0; is_push = 0; is_wr = 0; is_clr = 0;
      sz = 0; off = 0; m = 4'h0; a = RBASE;
      tx_ready = ($urandom_range(0, 2) == 0);
      if (op <= 2) begin
        is_wr = 1;
        off = $urandom_range(0, 255);
        case ($urandom_range(0, 2))
          0: begin sz = 1; m = 4'h1; end
          1: begin sz = 2; m = 4'h3; end
          default: begin sz = 4; m = 4'hF; end
        endcase
        a = RBASE + 32'(off);
      end else if (op <= 4) begin
        is_rd = 1;
        off = $urandom_range(0, 255);
        a = RBASE + 32'(off);
      end else if (op <= 7) begin
        is_push = 1; a = MMIO; m = 4'h1;
      end else if (op == 8) begin
        is_st = 1; a = MMIO + 4;
      end else begin
        is_clr = 1; a = MMIO + 4; d = 32'h4; m = 4'hF;
      end
      mem_addr = a; mem_wdata = d; mem_wenable = m;
      #1;
      check("rnd tx_valid", 32'(tx_valid), 32'(q.size() != 0));
      check("rnd tx_data", 32'(tx_data), (q.size() != 0) ? 32'(q[0]) : 32'h0);
      if (is_rd) begin
        exp_rd = 0;
        for (int k = 0; k < 4 - (off % 4); k++) exp_rd = exp_rd | (32'(ram_m[off + k]) << (8 * k));
        check("rnd ram read", mem_rdata, exp_rd);
      end
      if (is_st) check("rnd status", mem_rdata, exp_status(q.size(), ovf_m));
      @(posedge clk); #1;
      mem_wenable = 4'h0;
      if (tx_ready && q.size() != 0) void'(q.pop_front());
      if (is_push) begin
        if (q.size() < FDEPTH) q.push_back(d[7:0]);
        else ovf_m = 1'b1;
      end
      if (is_clr) ovf_m = 1'b0;
      exp_err = is_wr && ((off % 4) + sz > 4);
      if (is_wr) begin
        for (int j = 0; j < sz; j++) if ((off % 4) + j < 4) ram_m[off + j] = d[8*j +: 8];
      end
      check("rnd bus_err", 32'(bus_err), 32'(exp_err));
    end
    tx_ready = 1'b0;

    // Reset mid-stream.
    bus_write(MMIO, 32'h5A, 4'h1);
    bus_write(MMIO, 32'h5B, 4'h1);
    rst_n = 1'b0;
    mem_addr = 32'h100;
    #1;
    check("rdata held 0 in reset", mem_rdata, 32'h0);
    check("tx_valid before reset edge", 32'(tx_valid), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("tx_valid after reset", 32'(tx_valid), 32'h0);
    check("tx_data after reset", 32'(tx_data), 32'h0);
    bus_read(MMIO + 4, rd);
    check("status after reset", rd, exp_status(0, 0));
`ifdef MEM_BUS_RESPONDER_TIMER_EN
    bus_read(MMIO + 8, rd);
    check("timer after reset", rd, 32'h0);
`endif
    bus_read(32'h100, rd);
    check("ram survives reset", rd, 32'hDEADBEEF);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
